vga_timing_monitor: RTL



---
 rtl/vga_timing_pkg.sv | 36 +++
 rtl/vga_mon_axis.sv | 73 +++++++
 rtl/vga_timing_monitor.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared definitions for the VGA timing monitor:
//   - default 640x480 raster constants (visible, porches, sync, totals,
//     sync start/end column/line)
//   - monitor state enum
//   - saturating 8-bit increment used by the violation counter
package vga_timing_pkg;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;

    localparam int H_TOTAL_DEF      = H_DISPLAY_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF; // 800
    localparam int H_SYNC_START_DEF = H_DISPLAY_DEF + H_FP_DEF;                         // 656
    localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;                    // 752
    localparam int V_TOTAL_DEF      = V_DISPLAY_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF; // 525
    localparam int V_SYNC_START_DEF = V_DISPLAY_DEF + V_FP_DEF;                         // 490
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;                    // 492

    typedef enum logic [1:0] {
        SEARCH    = 2'd0,
        H_ALIGNED = 2'd1,
        VERIFY    = 2'd2,
        LOCKED    = 2'd3
    } mon_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/vga_mon_axis.sv
// vga_mon_axis
//   One axis (horizontal or vertical) of the raster tracker. Keeps a
//   free-running position counter, reloads it on the sync assertion edge and
//   checks that both sync edges land where the prediction says they should.
//
//   clk, rst   clock / synchronous active-high reset
//   pix_en     pixel tick; nothing moves without it
//   adv        advance enable (1 for H, H wrap for V)
//   sync       normalised sync (1 = asserted)
//   cnt        registered position of the last sampled pixel
//   cnt_next   position being assigned to the current sample
//   wrap       counter wraps TOTAL-1 -> 0 on this tick
//   rise       sync assertion edge on this tick
//   viol       edge-position violation on this tick
module vga_mon_axis
    import vga_timing_pkg::*;
#(
    parameter int TOTAL      = H_TOTAL_DEF,
    parameter int SYNC_START = H_SYNC_START_DEF,
    parameter int SYNC_END   = H_SYNC_END_DEF,
    parameter bit HOLD_CHECK = 1'b1,
    parameter int W          = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pix_en,
    input  logic         adv,
    input  logic         sync,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_next,
    output logic         wrap,
    output logic         rise,
    output logic         viol
);

    localparam logic [W-1:0] LAST  = W'(TOTAL - 1);
    localparam logic [W-1:0] START = W'(SYNC_START);
    localparam logic [W-1:0] STOP  = W'(SYNC_END);

    logic         sync_q;
    logic         fall;
    logic         held;
    logic [W-1:0] pred;

    // Free-running prediction, independent of what the sync pins say.
    always_comb begin
        pred = cnt;
        if (adv) pred = (cnt == LAST) ? '0 : cnt + 1'b1;
    end

    assign rise     = pix_en &  sync & ~sync_q;
    assign fall     = pix_en & ~sync &  sync_q;
    assign held     = pix_en &  sync &  sync_q;
    assign wrap     = pix_en & adv & (cnt == LAST);
    assign cnt_next = rise ? START : pred;

    // A sync still asserted at the predicted end position means the
    // deassertion edge went missing.
    assign viol = (rise && pred != START) ||
                  (fall && pred != STOP)  ||
                  (HOLD_CHECK && held && pred == STOP);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            sync_q <= 1'b0;
        end else if (pix_en) begin
            cnt    <= cnt_next;
            sync_q <= sync;
        end
    end

endmodule

// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor
//   Passive checker for a VGA raster. Recovers pixel coordinates from the
//   observed syncs, acquires lock after one clean frame and then flags any
//   timing deviation with sticky flags and a saturating counter.
//
//   Optional feature macro: VGA_MON_DE_CHECK_EN -- when defined, video_on is
//   compared against the recovered visible window and drives de_err; when
//   undefined video_on is ignored and de_err stays 0.
//
//   clk, rst          clock / synchronous active-high reset
//   pix_en            pixel tick
//   horizontal_sync   observed hsync (polarity set by SYNC_ACTIVE_LOW)
//   vertical_sync     observed vsync
//   video_on          observed display enable
//   clr_err           clears sticky flags and err_count (any clk edge)
//   x_rec, y_rec      recovered coordinate of the last sampled pixel
//   locked            raster tracked with no violation since lock
//   h_err/v_err/de_err sticky violation flags
//   err_count         saturating violation count
//   frame_cnt         frames completed while locked (wraps)
module vga_timing_monitor
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY       = H_DISPLAY_DEF,
    parameter int H_FP            = H_FP_DEF,
    parameter int H_SYNC          = H_SYNC_DEF,
    parameter int H_BP            = H_BP_DEF,
    parameter int V_DISPLAY       = V_DISPLAY_DEF,
    parameter int V_FP            = V_FP_DEF,
    parameter int V_SYNC          = V_SYNC_DEF,
    parameter int V_BP            = V_BP_DEF,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        horizontal_sync,
    input  logic        vertical_sync,
    input  logic        video_on,
    input  logic        clr_err,
    output logic [9:0]  x_rec,
    output logic [9:0]  y_rec,
    output logic        locked,
    output logic        h_err,
    output logic        v_err,
    output logic        de_err,
    output logic [7:0]  err_count,
    output logic [15:0] frame_cnt
);

    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int H_SS    = H_DISPLAY + H_FP;
    localparam int H_SE    = H_SS + H_SYNC;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int V_SS    = V_DISPLAY + V_FP;
    localparam int V_SE    = V_SS + V_SYNC;

    mon_state_t state;

    logic       hs, vs;
    logic [9:0] h_cnt, v_cnt, h_next, v_next;
    logic       h_wrap, v_wrap, h_rise, v_rise, h_viol, v_viol, de_viol;
    logic       checking, any_viol;
    logic       rep_h, rep_v, rep_de, rep_any;

    assign hs = SYNC_ACTIVE_LOW ? ~horizontal_sync : horizontal_sync;
    assign vs = SYNC_ACTIVE_LOW ? ~vertical_sync   : vertical_sync;

    vga_mon_axis #(
        .TOTAL(H_TOTAL), .SYNC_START(H_SS), .SYNC_END(H_SE),
        .HOLD_CHECK(1'b1), .W(10)
    ) u_h_axis (
        .clk(clk), .rst(rst), .pix_en(pix_en), .adv(1'b1), .sync(hs),
        .cnt(h_cnt), .cnt_next(h_next), .wrap(h_wrap), .rise(h_rise),
        .viol(h_viol)
    );

    // The vertical counter advances on the tick where the line wraps, so a
    // vsync edge aligned to column 0 already sees the new line number.
    vga_mon_axis #(
        .TOTAL(V_TOTAL), .SYNC_START(V_SS), .SYNC_END(V_SE),
        .HOLD_CHECK(1'b0), .W(10)
    ) u_v_axis (
        .clk(clk), .rst(rst), .pix_en(pix_en), .adv(h_wrap), .sync(vs),
        .cnt(v_cnt), .cnt_next(v_next), .wrap(v_wrap), .rise(v_rise),
        .viol(v_viol)
    );

    assign checking = (state == VERIFY) || (state == LOCKED);

`ifdef VGA_MON_DE_CHECK_EN
    logic de_exp;
    assign de_exp  = (h_next < 10'(H_DISPLAY)) && (v_next < 10'(V_DISPLAY));
    assign de_viol = pix_en && checking && (video_on != de_exp);
`else
    logic unused_video_on;
    assign unused_video_on = video_on;
    assign de_viol         = 1'b0;
`endif

    assign any_viol = h_viol | v_viol | de_viol;

    // Only violations seen while verifying or locked are reported; before
    // that they merely restart the search.
    assign rep_h   = checking & h_viol;
    assign rep_v   = checking & v_viol;
    assign rep_de  = de_viol;
    assign rep_any = rep_h | rep_v | rep_de;

    assign x_rec = h_cnt;
    assign y_rec = v_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEARCH;
            locked    <= 1'b0;
            h_err     <= 1'b0;
            v_err     <= 1'b0;
            de_err    <= 1'b0;
            err_count <= 8'd0;
            frame_cnt <= 16'd0;
        end else begin
            if (pix_en) begin
                unique case (state)
                    SEARCH: begin
                        if (h_rise) state <= H_ALIGNED;
                    end
                    H_ALIGNED: begin
                        if (h_viol)      state <= SEARCH;
                        else if (v_rise) state <= VERIFY;
                    end
                    VERIFY: begin
                        if (any_viol) begin
                            state <= SEARCH;
                        end else if (v_rise) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (any_viol) begin
                            state  <= SEARCH;
                            locked <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
                if (state == LOCKED && v_wrap) frame_cnt <= frame_cnt + 16'd1;
            end

            // A violation on the same edge as clr_err survives the clear.
            if (clr_err) begin
                h_err     <= rep_h;
                v_err     <= rep_v;
                de_err    <= rep_de;
                err_count <= rep_any ? 8'd1 : 8'd0;
            end else begin
                h_err  <= h_err  | rep_h;
                v_err  <= v_err  | rep_v;
                de_err <= de_err | rep_de;
                if (rep_any) err_count <= sat_inc8(err_count);
            end
        end
    end

endmodule
